// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//
// MEM-stage sequencer for the vector pipeline. A vector LDR/STR is split into
// LANES single-word accesses on a single-port, word-addressed data memory.
// A scalar access is handled the same way as one access to lane 0. The
// pipeline is stalled while the accesses run. A load result is assembled
// lane by lane into load_vec.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             MEM-stage instruction is a LDR/STR (held while stall=1)
//   is_store          1 = STR, 0 = LDR (sampled with start in IDLE)
//   is_vector         1 = LANES words, 0 = lane 0 only (sampled in IDLE)
//   base_addr         word address of lane 0 (sampled in IDLE)
//   store_vec         packed store data, lane i at [i*DATA_W +: DATA_W]
//   mem_rdata         memory read data, valid one cycle after mem_re
//   mem_addr/wdata    registered memory address / write data
//   mem_we/mem_re     registered write / read strobes (never both high)
//   load_vec          assembled load data, same packing as store_vec
//   stall             freeze IF..MEM while the sequence runs
//   done              one-cycle completion pulse
//
// Timing: start is seen in cycle 0, and lane k is on the memory bus in
// cycle k+1. A store finishes (done) in cycle N+1. A load needs one extra
// DRAIN cycle to collect the last read word, so it finishes in cycle N+2.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic                    is_vector,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] store_vec,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [LANES*DATA_W-1:0] load_vec,
  output logic                    stall,
  output logic                    done
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        lane;
  logic                    is_store_q;
  logic                    is_vector_q;
  logic [ADDR_W-1:0]       base_q;
  logic [LANES*DATA_W-1:0] store_q;
  logic                    last_lane;

  // Address of lane k; wraps modulo 2^ADDR_W by truncation.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] b,
                                                  input int k);
    lane_addr = b + ADDR_W'(k);
  endfunction

  // Extract lane k of a packed vector; out-of-range lanes read as zero.
  function automatic logic [DATA_W-1:0] lane_word(input logic [LANES*DATA_W-1:0] v,
                                                  input int k);
    if (k < LANES) lane_word = v[k*DATA_W +: DATA_W];
    else           lane_word = '0;
  endfunction

  // A scalar access is always on its last (only) lane.
  assign last_lane = is_vector_q ? (lane == CNT_W'(LANES - 1)) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // The capture cycle itself is already stalled.
        stall = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (last_lane) state_nxt = is_store_q ? DONE : DRAIN;
      end
      DRAIN: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // start is ignored here so a held start cannot retrigger.
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction operands, latched on acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q  <= base_addr;
      store_q <= store_vec;
    end
  end

  // Memory bus is registered: the bus value for lane k is loaded at the
  // edge that enters lane k, so it is stable for the whole RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane        <= '0;
      is_store_q  <= 1'b0;
      is_vector_q <= 1'b0;
      load_vec    <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_store_q  <= is_store;
            is_vector_q <= is_vector;
            lane        <= '0;
            mem_addr    <= base_addr;
            mem_wdata   <= lane_word(store_vec, 0);
            mem_we      <= is_store;
            mem_re      <= ~is_store;
          end
        end
        RUN: begin
          // The read issued for lane k-1 returns during lane k.
          if (!is_store_q && lane != '0)
            load_vec[(int'(lane) - 1)*DATA_W +: DATA_W] <= mem_rdata;
          if (last_lane) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
          end else begin
            lane      <= lane + CNT_W'(1);
            mem_addr  <= lane_addr(base_q, int'(lane) + 1);
            if (is_store_q) mem_wdata <= lane_word(store_q, int'(lane) + 1);
          end
        end
        DRAIN: begin
          // lane still holds N-1 here.
          load_vec[int'(lane)*DATA_W +: DATA_W] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    is_store;
  logic                    is_vector;
  logic [ADDR_W-1:0]       base_addr;
  logic [LANES*DATA_W-1:0] store_vec;
  logic [DATA_W-1:0]       mem_rdata;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic                    mem_re;
  logic [LANES*DATA_W-1:0] load_vec;
  logic                    stall;
  logic                    done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mem [0:65535];

  vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .is_vector (is_vector),
    .base_addr (base_addr),
    .store_vec (store_vec),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .load_vec  (load_vec),
    .stall     (stall),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; that cycle becomes cycle 0. Returns in the
  // IDLE cycle after DONE.
  task automatic run_store(input logic [15:0] base, input logic [63:0] vec,
                           input bit vector, input bit hold);
    int n;
    logic [15:0] ea;
    n = vector ? LANES : 1;
    start = 1'b1; is_store = 1'b1; is_vector = vector; base_addr = base; store_vec = vec;
    #1;
    chk("st_c0_stall", stall, 1);
    chk("st_c0_we", mem_we, 0);
    for (int k = 0; k < n; k++) begin
      next();
      ea = base + 16'(k);
      chk("st_we", mem_we, 1);
      chk("st_re", mem_re, 0);
      chk("st_addr", mem_addr, ea);
      chk("st_wdata", mem_wdata, vec[k*16 +: 16]);
      chk("st_stall", stall, 1);
      chk("st_done_early", done, 0);
    end
    next();
    chk("st_done", done, 1);
    chk("st_done_stall", stall, 0);
    chk("st_done_we", mem_we, 0);
    if (!hold) start = 1'b0;
    next();
    chk("st_idle_done", done, 0);
    chk("st_idle_we", mem_we, 0);
    chk("st_idle_re", mem_re, 0);
    chk("st_idle_stall", stall, hold ? 1 : 0);
  endtask

  task automatic run_load(input logic [15:0] base, input bit vector,
                          input logic [63:0] exp_vec);
    int n;
    logic [15:0] ea;
    n = vector ? LANES : 1;
    start = 1'b1; is_store = 1'b0; is_vector = vector; base_addr = base;
    store_vec = 64'h5555_5555_5555_5555;
    #1;
    chk("ld_c0_stall", stall, 1);
    for (int k = 0; k < n; k++) begin
      next();
      ea = base + 16'(k);
      chk("ld_re", mem_re, 1);
      chk("ld_we", mem_we, 0);
      chk("ld_addr", mem_addr, ea);
      chk("ld_stall", stall, 1);
    end
    next();
    chk("ld_drain_re", mem_re, 0);
    chk("ld_drain_stall", stall, 1);
    chk("ld_drain_done", done, 0);
    next();
    chk("ld_done", done, 1);
    chk("ld_done_stall", stall, 0);
    chk("ld_vec", load_vec, exp_vec);
    start = 1'b0;
    next();
    chk("ld_idle_done", done, 0);
    chk("ld_vec_hold", load_vec, exp_vec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0020] = 16'h000A;
    mem[16'h0021] = 16'h000B;
    mem[16'h0022] = 16'h000C;
    mem[16'h0023] = 16'h000D;
    mem[16'h0005] = 16'hBEEF;
    mem_rdata = '0;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; is_vector = 1'b0;
    base_addr = '0; store_vec = '0;
    next(); next(); next();

    // Reset state
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_load_vec", load_vec, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    next();
    chk("post_rst_we", mem_we, 0);

    // Vector store
    run_store(16'h0010, 64'h4444_3333_2222_1111, 1'b1, 1'b0);
    chk("vst_mem10", mem[16'h0010], 16'h1111);
    chk("vst_mem13", mem[16'h0013], 16'h4444);
    chk("vst_load_vec", load_vec, 0);

    // Vector load
    run_load(16'h0020, 1'b1, 64'h000D_000C_000B_000A);

    // Scalar load: lane 0 only
    run_load(16'h0005, 1'b0, 64'h000D_000C_000B_BEEF);

    // Scalar store: exactly one write, load_vec untouched
    run_store(16'h0030, 64'h9999_8888_7777_5A5A, 1'b0, 1'b0);
    chk("sst_mem30", mem[16'h0030], 16'h5A5A);
    chk("sst_mem31", mem[16'h0031], 16'h0000);
    chk("sst_load_vec", load_vec, 64'h000D_000C_000B_BEEF);

    // Address wrap
    run_store(16'hFFFE, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
    chk("wrap_memFFFE", mem[16'hFFFE], 16'h0001);
    chk("wrap_memFFFF", mem[16'hFFFF], 16'h0002);
    chk("wrap_mem0000", mem[16'h0000], 16'h0003);
    chk("wrap_mem0001", mem[16'h0001], 16'h0004);

    // Reset in the middle of a load (RUN lane 2 = cycle 3)
    start = 1'b1; is_store = 1'b0; is_vector = 1'b1; base_addr = 16'h0020;
    #1;
    next(); next(); next();
    chk("rml_re_lane2", mem_re, 1);
    chk("rml_addr_lane2", mem_addr, 16'h0022);
    rst = 1'b1; start = 1'b0;
    next();
    rst = 1'b0;
    #1;
    chk("rml_re", mem_re, 0);
    chk("rml_we", mem_we, 0);
    chk("rml_load_vec", load_vec, 0);
    chk("rml_stall", stall, 0);
    chk("rml_addr", mem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rml_no_done", done, 0);
      next();
    end
    run_load(16'h0020, 1'b1, 64'h000D_000C_000B_000A);

    // start held through DONE, second start taken in the following IDLE
    run_store(16'h0040, 64'h0D0D_0C0C_0B0B_0A0A, 1'b1, 1'b1);
    run_store(16'h0050, 64'h0000_0000_0000_7E7E, 1'b0, 1'b0);
    chk("held_mem43", mem[16'h0043], 16'h0D0D);
    chk("held_mem50", mem[16'h0050], 16'h7E7E);
    chk("held_mem44", mem[16'h0044], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
Multi-cycle sequencer for the MEM stage of the vector pipeline. It serialises vector LDR/STR instructions into per-lane accesses on the single-port, word-addressed data memory. It stalls the pipeline while the accesses run and presents the assembled load vector on completion. Scalar memory instructions pass through as single-lane transfers. It is driven by the decoded memory-type signals (MemWrite/MemtoReg, vector flag).

Parameters:
LANES, 4, number of vector lanes (>=1)
DATA_W, 16, lane/memory word width in bits
ADDR_W, 16, data memory word-address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  MEM-stage instruction is LDR/STR; held high by the pipeline while stall=1
is_store  in  1  1=STR, 0=LDR; sampled with start in IDLE
is_vector  in  1  1=vector access (LANES words), 0=scalar (lane 0 only); sampled with start in IDLE
base_addr  in  ADDR_W  word address of lane 0; sampled with start in IDLE
store_vec  in  LANES*DATA_W  store data; lane i = bits [i*DATA_W +: DATA_W]; sampled with start in IDLE
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
load_vec  out  LANES*DATA_W  assembled load result, same lane packing as store_vec
stall  out  1  freeze IF..MEM stages
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, lane counter=0, load_vec=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, done=0. A reset mid-operation aborts the operation. No write is issued in the cycle after reset. stall is 0 unless start is asserted.
- Lane count N = LANES if is_vector else 1.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1: latch is_store, is_vector, base_addr, store_vec; set lane=0; go to RUN.
  - stall = start (combinational) in IDLE, so the capture cycle is already stalled.
- RUN, lane k:
  - mem_addr = base_addr + k, truncated modulo 2^ADDR_W (wrap permitted, no error).
  - Store: mem_we=1, mem_wdata=latched lane k.
  - Load: mem_re=1, and the word issued in the previous RUN cycle (lane k-1) is captured into load_vec lane k-1.
  - stall=1. On k=N-1: store goes to DONE, load goes to DRAIN. Otherwise k increments.
- DRAIN (load only): capture mem_rdata into lane N-1; mem_re=0; stall=1; go to DONE.
- DONE:
  - done=1 and stall=0; the pipeline advances this cycle.
  - start is ignored in DONE; return to IDLE unconditionally.
- mem_we and mem_re are never both 1. Both are 0 in IDLE, DRAIN and DONE.
- Latency from the start cycle (cycle 0) to the done cycle:
  - Store: N+1 cycles, so done is in cycle N+1.
  - Load: N+2 cycles, so done is in cycle N+2.
- Scalar load updates lane 0 only. Other lanes hold their previous value.
- load_vec holds its value after done until the next load overwrites lanes. Stores never modify load_vec.
- Back-to-back instructions: a new start is first accepted in the IDLE cycle following DONE.
- mem_addr and mem_wdata hold their last values when no strobe is active.

Test Plan:
- Vector store: LANES=4, base=0x0010, store_vec lanes {0x1111,0x2222,0x3333,0x4444} -> we=1 at addr 0x10..0x13 with matching data on cycles 1..4; done in cycle 5; stall high cycles 0..4.
- Vector load: memory 0x20..0x23 = {0xA,0xB,0xC,0xD}, base=0x20 -> re on cycles 1..4; done in cycle 6 with load_vec lanes 0..3 = {0xA,0xB,0xC,0xD}.
- Scalar load then scalar store: scalar LDR base=0x5 (mem=0xBEEF) -> lane0=0xBEEF, other lanes unchanged, done in cycle 3. Following STR -> exactly one write, done 2 cycles after its start.
- Address wrap: vector store base=0xFFFE -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-load: rst asserted at RUN lane 2 -> next cycle IDLE, strobes 0, load_vec=0, done never pulses. A subsequent start completes normally.
- start held through DONE: no retrigger. A second start raised in the following IDLE cycle begins a new sequence with correct latency.
